booth_mult_seq: RTL



---
 rtl/booth_mult_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/booth_mult_seq.sv
// -----------------------------------------------------------------------------
// booth_mult_seq
//   Radix-2 Booth sequential multiplier with its own operand/accumulator
//   registers and control FSM. Operands may be treated as signed or unsigned
//   per operation. Each operation takes a fixed WIDTH+1 iterations, after which
//   the product register is updated and done pulses for one cycle.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   start         request, only looked at in IDLE or DONE
//   sign_mode     1 = two's-complement operands, 0 = unsigned operands
//   multiplicand  operand M, captured on the accepting edge
//   multiplier    operand Q, captured on the accepting edge
//   busy          high while iterating (CALC)
//   done          one-cycle pulse when product has just been updated
//   product       2*WIDTH-bit result, held until the next completion
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start
// CALC   | one Booth add/sub + arithmetic shift per clock
// DONE   | product freshly loaded; start here is accepted back-to-back
// -----------------------------------------------------------------------------
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sign_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Operands are extended by one bit so that the unsigned all-ones value and
    // the signed most-negative value are both representable in the same datapath.
    localparam int XW = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] ITERS = CW'(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [XW-1:0]       acc_q, acc_d;
    logic [XW-1:0]       mq_q, mq_d;
    logic                qm1_q, qm1_d;
    logic [XW-1:0]       mcand_q, mcand_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [2*WIDTH-1:0]  product_q, product_d;

    logic [XW-1:0]       m_ext;
    logic [XW-1:0]       q_ext;
    logic [XW-1:0]       acc_sum;
    logic [XW-1:0]       acc_shr;
    logic [XW-1:0]       mq_shr;

    always_comb begin
        m_ext = sign_mode ? {multiplicand[WIDTH-1], multiplicand} : {1'b0, multiplicand};
        q_ext = sign_mode ? {multiplier[WIDTH-1], multiplier}     : {1'b0, multiplier};

        unique case ({mq_q[0], qm1_q})
            2'b01:   acc_sum = acc_q + mcand_q;
            2'b10:   acc_sum = acc_q - mcand_q;
            default: acc_sum = acc_q;
        endcase

        // Arithmetic right shift of {A, Q, Q-1}
        acc_shr = {acc_sum[XW-1], acc_sum[XW-1:1]};
        mq_shr  = {acc_sum[0], mq_q[XW-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        qm1_d     = qm1_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        product_d = product_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_CALC;
                    acc_d   = '0;
                    mq_d    = q_ext;
                    qm1_d   = 1'b0;
                    mcand_d = m_ext;
                    cnt_d   = ITERS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                acc_d = acc_shr;
                mq_d  = mq_shr;
                qm1_d = mq_q[0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    // Low 2*WIDTH bits of the post-shift {A, Q}
                    product_d = {acc_shr[WIDTH-2:0], mq_shr};
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_CALC);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mq_q      <= '0;
            qm1_q     <= 1'b0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            qm1_q     <= qm1_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
